snd_dma_ctrl: RTL and testbench
===============================

# snd_dma_ctrl

Parametrised multi-channel sound DMA controller: generates word fetch addresses for up to CHANNELS independent sound frames, with frame start/end compare, repeat mode, end-of-frame interrupt and per-channel request credit. It sits next to the MCU bus-cycle control, consumes the sound-slot strobe from bus timing and drives the sound address/load path toward the RAM controller and sound shifter. It extends the single-channel sndon/sfrep/sint/stoff scheme with multiple channels, arbitration and buffered requests.

## Interface
- CHANNELS, 2, number of sound channels (1..8)
- AW, 21, word address width; addresses are [AW:1]
- CREDIT_DEPTH, 4, max outstanding word requests per channel (power of 2, >=2)
- clk32  in  1  system clock; all state on rising edge
- porb  in  1  asynchronous, active-low reset
- slot_en  in  1  one-cycle strobe: a sound DMA bus slot is available this cycle
- sndon  in  CHANNELS  per-channel enable, level
- sfrep  in  CHANNELS  per-channel repeat mode, level
- frame_start  in  CHANNELS*AW  per-channel frame start word address, channel c at [c*AW +: AW]
- frame_end  in  CHANNELS*AW  per-channel frame end word address (exclusive)
- sreq  in  CHANNELS  one-cycle pulse: shifter wants one more word from channel c
- snd_addr  out  AW  fetch address, valid while sload=1
- sch  out  clog2(CHANNELS) (min 1)  channel of current fetch
- sload  out  1  one-cycle pulse: fetch snd_addr for channel sch
- active  out  CHANNELS  channel is running a frame
- sint  out  CHANNELS  one-cycle pulse at each frame end
- stoff  out  CHANNELS  one-cycle pulse when a channel stops at frame end or start is rejected
- ovf  out  CHANNELS  sticky: sreq arrived with credit full; cleared when channel leaves RUN

## Operation
- Per-channel states: IDLE, RUN. Reset: all IDLE.
- IDLE -> RUN: sndon=1 sampled in IDLE. Latch shadow start/end from frame_start/frame_end, counter := start, credit := 0, ovf := 0. If start == end: stay IDLE, pulse stoff, do not latch (re-arms only after sndon goes 0 then 1).
- RUN -> IDLE: sndon=0 on any cycle (no sint, no stoff); credit cleared; an in-flight grant in that same cycle is suppressed.
- Credit: sreq increments, grant decrements, both in same cycle -> unchanged; sreq at credit==CREDIT_DEPTH is dropped and sets ovf.
- Eligible: RUN, sndon=1, credit>0. On slot_en with >=1 eligible, round-robin grant: search from last_granted+1 upward mod CHANNELS; last_granted resets to CHANNELS-1 (channel 0 wins first).
- Grant of channel c: register snd_addr := counter, sch := c, sload := 1; next := counter+1 mod 2^AW.
- Frame end when next == shadow end: pulse sint[c]; if sfrep[c]=1 relatch shadows from current frame_start/frame_end and counter := new start (new start==new end -> stop as below); else channel -> IDLE and pulse stoff[c]. Otherwise counter := next.
- Counter wraps mod 2^AW; end < start is legal (frame crosses wrap).
- Start/end inputs are only sampled at frame begin; changes mid-frame take effect at next frame.

## Timing
- Reset values: snd_addr=0, sch=0, sload=0, active=0, sint=0, stoff=0, ovf=0.
- sndon high -> active high 1 cycle later; first fetch possible on next slot_en after first sreq.
- slot_en in cycle N -> sload/snd_addr/sch valid in cycle N+1, sint/stoff (frame end) also in N+1, active drops in N+1.
- At most one grant per slot_en; no slot_en -> sload=0.
- sreq in cycle N counts toward eligibility in cycle N+1.
- porb low mid-frame: immediate return to reset values, no pulses.

## Structure
- Package snd_dma_pkg: channel state enum (IDLE, RUN), clog2 helper, channel-index width constant.
- Sub-module snd_dma_chan (one per channel, generate loop): shadow regs, address counter, credit counter, state, sint/stoff/ovf; top holds round-robin arbiter and output registers.

## Test plan
- Single channel, start=0x100, end=0x104, sfrep=0, 4 sreq, slot_en each cycle -> sload addrs 0x100..0x103, sint and stoff pulse with 0x103 fetch, active=0 after.
- sfrep=1, start=0x1FFFFE end=0x000001 (AW=21) -> addrs 0x1FFFFE,0x1FFFFF,0x000000, sint, then 0x1FFFFE again, no stoff.
- Two channels both eligible on every slot -> grants alternate 0,1,0,1; channel 0 first after reset.
- 5 sreq pulses with no slot_en, CREDIT_DEPTH=4 -> ovf[c]=1, exactly 4 fetches after slots resume.
- sndon dropped in same cycle as slot_en for only eligible channel -> no sload, no sint/stoff, active=0 next cycle, ovf cleared.
- start==end with sndon=1 -> stoff one pulse, active stays 0; porb asserted mid-frame -> all outputs 0.

Source files
------------

// File: rtl/snd_dma_pkg.sv
// Shared types and width helpers for the multi-channel sound DMA controller.
package snd_dma_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_t;

  localparam int MAX_CHANNELS = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width; a single channel still gets a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  localparam int MAX_IDX_W = idx_width(MAX_CHANNELS);

endpackage

// File: rtl/snd_dma_chan.sv
// One sound DMA channel: frame shadow, word address counter, request credit
// and the IDLE/RUN sequencing with its sint/stoff/ovf flags.
module snd_dma_chan
  import snd_dma_pkg::*;
#(
  parameter int AW           = 21,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic          clk32,
  input  logic          porb,
  input  logic          sndon,
  input  logic          sfrep,
  input  logic [AW-1:0] frame_start,
  input  logic [AW-1:0] frame_end,
  input  logic          sreq,
  input  logic          grant,
  output logic          eligible,
  output logic [AW-1:0] addr,
  output logic          active,
  output logic          sint,
  output logic          stoff,
  output logic          ovf
);

  localparam int            CW          = clog2(CREDIT_DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_DEPTH);

  chan_state_t   state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] end_reg, end_next;
  logic [AW-1:0] cnt_inc;
  logic [CW-1:0] credit_reg, credit_next;
  logic          hold_reg, hold_next;
  logic          ovf_reg, ovf_next;
  logic          sint_reg, sint_next;
  logic          stoff_reg, stoff_next;
  logic          credit_add;

  assign cnt_inc  = cnt_reg + AW'(1);
  assign eligible = (state_reg == CH_RUN) && sndon && (credit_reg != '0);
  assign addr     = cnt_reg;
  assign active   = (state_reg == CH_RUN);
  assign sint     = sint_reg;
  assign stoff    = stoff_reg;
  assign ovf      = ovf_reg;

  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      state_reg  <= CH_IDLE;
      cnt_reg    <= '0;
      end_reg    <= '0;
      credit_reg <= '0;
      hold_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      sint_reg   <= 1'b0;
      stoff_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      end_reg    <= end_next;
      credit_reg <= credit_next;
      hold_reg   <= hold_next;
      ovf_reg    <= ovf_next;
      sint_reg   <= sint_next;
      stoff_reg  <= stoff_next;
    end
  end

  // hold blocks restarting after a stop or reject until sndon has gone low.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    end_next    = end_reg;
    credit_next = credit_reg;
    hold_next   = hold_reg;
    ovf_next    = ovf_reg;
    sint_next   = 1'b0;
    stoff_next  = 1'b0;
    credit_add  = 1'b0;
    case (state_reg)
      CH_IDLE: begin
        credit_next = '0;
        ovf_next    = 1'b0;
        if (!sndon) begin
          hold_next = 1'b0;
        end else if (!hold_reg) begin
          if (frame_start == frame_end) begin
            stoff_next = 1'b1;
            hold_next  = 1'b1;
          end else begin
            state_next = CH_RUN;
            cnt_next   = frame_start;
            end_next   = frame_end;
          end
        end
      end
      CH_RUN: begin
        if (!sndon) begin
          state_next  = CH_IDLE;
          credit_next = '0;
          ovf_next    = 1'b0;
        end else begin
          if (sreq) begin
            if (credit_reg == CREDIT_FULL) ovf_next = 1'b1;
            else credit_add = 1'b1;
          end
          if (credit_add && !grant) credit_next = credit_reg + CW'(1);
          else if (!credit_add && grant) credit_next = credit_reg - CW'(1);
          if (grant) begin
            if (cnt_inc == end_reg) begin
              sint_next = 1'b1;
              if (sfrep && (frame_start != frame_end)) begin
                cnt_next = frame_start;
                end_next = frame_end;
              end else begin
                state_next  = CH_IDLE;
                stoff_next  = 1'b1;
                hold_next   = 1'b1;
                credit_next = '0;
                ovf_next    = 1'b0;
              end
            end else begin
              cnt_next = cnt_inc;
            end
          end
        end
      end
      default: begin
        state_next = CH_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/snd_dma_ctrl.sv
// Multi-channel sound DMA controller: per-channel frame engines plus a
// round-robin slot arbiter driving the registered fetch address/load path.
module snd_dma_ctrl
  import snd_dma_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int AW           = 21,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic                               clk32,
  input  logic                               porb,
  input  logic                               slot_en,
  input  logic [CHANNELS-1:0]                sndon,
  input  logic [CHANNELS-1:0]                sfrep,
  input  logic [CHANNELS*AW-1:0]             frame_start,
  input  logic [CHANNELS*AW-1:0]             frame_end,
  input  logic [CHANNELS-1:0]                sreq,
  output logic [AW-1:0]                      snd_addr,
  output logic [idx_width(CHANNELS)-1:0]     sch,
  output logic                               sload,
  output logic [CHANNELS-1:0]                active,
  output logic [CHANNELS-1:0]                sint,
  output logic [CHANNELS-1:0]                stoff,
  output logic [CHANNELS-1:0]                ovf
);

  localparam int IW = idx_width(CHANNELS);

  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] grant_vec;
  logic [AW-1:0]       chan_addr [CHANNELS];
  logic [IW-1:0]       last_reg;
  logic [IW-1:0]       grant_idx;
  logic [IW:0]         rr_sum;
  logic                grant_any;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      snd_dma_chan #(
        .AW           (AW),
        .CREDIT_DEPTH (CREDIT_DEPTH)
      ) u_chan (
        .clk32       (clk32),
        .porb        (porb),
        .sndon       (sndon[gi]),
        .sfrep       (sfrep[gi]),
        .frame_start (frame_start[gi*AW +: AW]),
        .frame_end   (frame_end[gi*AW +: AW]),
        .sreq        (sreq[gi]),
        .grant       (grant_vec[gi]),
        .eligible    (eligible[gi]),
        .addr        (chan_addr[gi]),
        .active      (active[gi]),
        .sint        (sint[gi]),
        .stoff       (stoff[gi]),
        .ovf         (ovf[gi])
      );
    end
  endgenerate

  // Search starts one past the last winner and wraps, so every eligible
  // channel is served within CHANNELS slots.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    rr_sum    = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      rr_sum = {1'b0, last_reg} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(CHANNELS)) rr_sum = rr_sum - (IW+1)'(CHANNELS);
      if (slot_en && !grant_any && eligible[rr_sum[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = rr_sum[IW-1:0];
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      snd_addr <= '0;
      sch      <= '0;
      sload    <= 1'b0;
      last_reg <= IW'(CHANNELS - 1);
    end else begin
      sload <= grant_any;
      if (grant_any) begin
        snd_addr <= chan_addr[grant_idx];
        sch      <= grant_idx;
        last_reg <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_snd_dma_ctrl.sv
// Self-checking bench for snd_dma_ctrl: directed frame scenarios plus a long
// randomized run against a cycle-level behavioural model.
module tb_snd_dma_ctrl;

  localparam int NCH   = 2;
  localparam int AW    = 21;
  localparam int DEPTH = 4;
  localparam int AMASK = (1 << AW) - 1;

  logic              clk32 = 1'b0;
  logic              porb = 1'b0;
  logic              slot_en = 1'b0;
  logic [NCH-1:0]    sndon = '0;
  logic [NCH-1:0]    sfrep = '0;
  logic [NCH-1:0]    sreq = '0;
  logic [NCH*AW-1:0] frame_start = '0;
  logic [NCH*AW-1:0] frame_end = '0;
  logic [AW-1:0]     snd_addr;
  logic [0:0]        sch;
  logic              sload;
  logic [NCH-1:0]    active, sint, stoff, ovf;

  snd_dma_ctrl #(.CHANNELS(NCH), .AW(AW), .CREDIT_DEPTH(DEPTH)) dut (
    .clk32       (clk32),
    .porb        (porb),
    .slot_en     (slot_en),
    .sndon       (sndon),
    .sfrep       (sfrep),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .sreq        (sreq),
    .snd_addr    (snd_addr),
    .sch         (sch),
    .sload       (sload),
    .active      (active),
    .sint        (sint),
    .stoff       (stoff),
    .ovf         (ovf)
  );

  always #5 clk32 = ~clk32;

  // Reference model state: one frame engine per channel plus the slot pointer.
  bit m_run [NCH];
  bit m_hold [NCH];
  bit m_ovf [NCH];
  int m_ptr [NCH];
  int m_end [NCH];
  int m_credit [NCH];
  int m_last;
  bit           e_sload;
  int           e_addr, e_sch;
  bit [NCH-1:0] e_sint, e_stoff;

  int n_tests = 0;
  int n_fail = 0;
  bit verbose = 1'b0;
  int cap_ch[$];
  int cap_addr[$];
  int sint_seen [NCH];
  int stoff_seen [NCH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_frame(input int c, input int s, input int e);
    frame_start[c*AW +: AW] = AW'(s);
    frame_end[c*AW +: AW]   = AW'(e);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_hold[c] = 0; m_ovf[c] = 0;
      m_ptr[c] = 0; m_end[c] = 0; m_credit[c] = 0;
    end
    m_last = NCH - 1;
  endtask

  task automatic model_step();
    int g, cc, fs, fe, nxt;
    e_sload = 0; e_sint = '0; e_stoff = '0; g = -1;
    if (slot_en) begin
      for (int k = 1; k <= NCH; k++) begin
        cc = (m_last + k) % NCH;
        if (g < 0 && m_run[cc] && sndon[cc] && m_credit[cc] > 0) g = cc;
      end
    end
    if (g >= 0) begin
      e_sload = 1; e_addr = m_ptr[g]; e_sch = g; m_last = g;
    end
    for (int c = 0; c < NCH; c++) begin
      fs = int'(frame_start[c*AW +: AW]);
      fe = int'(frame_end[c*AW +: AW]);
      if (!m_run[c]) begin
        m_credit[c] = 0; m_ovf[c] = 0;
        if (!sndon[c]) m_hold[c] = 0;
        else if (!m_hold[c]) begin
          if (fs == fe) begin
            e_stoff[c] = 1; m_hold[c] = 1;
          end else begin
            m_run[c] = 1; m_ptr[c] = fs; m_end[c] = fe;
          end
        end
      end else if (!sndon[c]) begin
        m_run[c] = 0; m_credit[c] = 0; m_ovf[c] = 0;
      end else begin
        if (sreq[c]) begin
          if (m_credit[c] == DEPTH) m_ovf[c] = 1;
          else m_credit[c] = m_credit[c] + 1;
        end
        if (g == c) begin
          m_credit[c] = m_credit[c] - 1;
          nxt = (m_ptr[c] + 1) & AMASK;
          if (nxt == m_end[c]) begin
            e_sint[c] = 1;
            if (sfrep[c] && fs != fe) begin
              m_ptr[c] = fs; m_end[c] = fe;
            end else begin
              m_run[c] = 0; m_hold[c] = 1; m_credit[c] = 0; m_ovf[c] = 0;
              e_stoff[c] = 1;
            end
          end else begin
            m_ptr[c] = nxt;
          end
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [NCH-1:0] e_act, e_ovf;
    for (int c = 0; c < NCH; c++) begin
      e_act[c] = m_run[c];
      e_ovf[c] = m_ovf[c];
    end
    check_eq("sload", sload, e_sload);
    if (e_sload) begin
      check_eq("snd_addr", snd_addr, e_addr);
      check_eq("sch", sch, e_sch);
    end
    check_eq("active", active, e_act);
    check_eq("sint", sint, e_sint);
    check_eq("stoff", stoff, e_stoff);
    check_eq("ovf", ovf, e_ovf);
    if (sload) begin
      cap_ch.push_back(int'(sch));
      cap_addr.push_back(int'(snd_addr));
      if (verbose) $display("[TB] fetch ch=%0d addr=0x%06h sint=%b stoff=%b", sch, snd_addr, sint, stoff);
    end
    for (int c = 0; c < NCH; c++) begin
      if (sint[c]) sint_seen[c]++;
      if (stoff[c]) stoff_seen[c]++;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk32);
    #1;
    compare_outputs();
  endtask

  task automatic clear_cap();
    cap_ch.delete();
    cap_addr.delete();
    for (int c = 0; c < NCH; c++) begin
      sint_seen[c] = 0; stoff_seen[c] = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sload"}, sload, 0);
    check_eq({tag, "_addr"}, snd_addr, 0);
    check_eq({tag, "_sch"}, sch, 0);
    check_eq({tag, "_active"}, active, 0);
    check_eq({tag, "_sint"}, sint, 0);
    check_eq({tag, "_stoff"}, stoff, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
  endtask

  task automatic do_reset();
    porb = 1'b0; slot_en = 1'b0; sndon = '0; sfrep = '0; sreq = '0;
    @(posedge clk32);
    #1;
    check_all_zero("rst");
    model_reset();
    @(posedge clk32);
    #1;
    porb = 1'b1;
  endtask

  initial begin
    int exp_b [4];
    int s;
    exp_b = '{'h1FFFFE, 'h1FFFFF, 'h000000, 'h1FFFFE};

    // Single frame, no repeat.
    do_reset();
    verbose = 1'b1;
    clear_cap();
    set_frame(0, 'h100, 'h104);
    sndon = 2'b01;
    step();
    check_eq("A_active_on", active[0], 1);
    sreq = 2'b01; slot_en = 1'b1;
    repeat (4) step();
    sreq = '0;
    repeat (4) step();
    check_eq("A_nfetch", cap_addr.size(), 4);
    for (int i = 0; i < cap_addr.size() && i < 4; i++) check_eq("A_addr", cap_addr[i], 'h100 + i);
    check_eq("A_sint", sint_seen[0], 1);
    check_eq("A_stoff", stoff_seen[0], 1);
    check_eq("A_active_off", active[0], 0);
    sndon = '0;
    step();

    // Repeat mode across the address wrap.
    do_reset();
    clear_cap();
    set_frame(0, 'h1FFFFE, 'h000001);
    sfrep = 2'b01; sndon = 2'b01;
    step();
    sreq = 2'b01; slot_en = 1'b1;
    repeat (4) step();
    sreq = '0;
    repeat (3) step();
    check_eq("B_nfetch", cap_addr.size(), 4);
    for (int i = 0; i < cap_addr.size() && i < 4; i++) check_eq("B_addr", cap_addr[i], exp_b[i]);
    check_eq("B_sint", sint_seen[0], 1);
    check_eq("B_stoff", stoff_seen[0], 0);
    check_eq("B_active", active[0], 1);

    // Two channels contending for every slot.
    do_reset();
    clear_cap();
    set_frame(0, 'h10, 'h20);
    set_frame(1, 'h40, 'h50);
    sndon = 2'b11;
    step();
    sreq = 2'b11;
    repeat (4) step();
    slot_en = 1'b1;
    repeat (6) step();
    check_eq("C_nfetch", cap_ch.size(), 6);
    for (int i = 0; i < cap_ch.size() && i < 6; i++) check_eq("C_sch", cap_ch[i], i % 2);
    porb = 1'b0;
    #1;
    check_all_zero("C_midrst");

    // Credit overflow, then drain.
    do_reset();
    set_frame(0, 'h200, 'h300);
    sndon = 2'b01;
    step();
    sreq = 2'b01;
    repeat (5) step();
    check_eq("D_ovf_set", ovf[0], 1);
    clear_cap();
    sreq = '0; slot_en = 1'b1;
    repeat (8) step();
    check_eq("D_nfetch", cap_addr.size(), 4);
    check_eq("D_ovf_sticky", ovf[0], 1);

    // sndon dropped in the same cycle as the only possible grant.
    sreq = 2'b01; slot_en = 1'b0;
    step();
    sreq = '0; slot_en = 1'b1; sndon = '0;
    step();
    check_eq("E_sload", sload, 0);
    check_eq("E_active", active[0], 0);
    check_eq("E_ovf", ovf[0], 0);
    check_eq("E_sint", sint[0], 0);
    check_eq("E_stoff", stoff[0], 0);

    // Empty frame is rejected once.
    do_reset();
    clear_cap();
    set_frame(1, 'h500, 'h500);
    sndon = 2'b10;
    repeat (6) step();
    check_eq("F_stoff", stoff_seen[1], 1);
    check_eq("F_active", active, 0);
    check_eq("F_sint", sint_seen[1], 0);

    // Randomized traffic against the model.
    verbose = 1'b0;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 29) == 0) sndon[c] = ~sndon[c];
        if ($urandom_range(0, 49) == 0) sfrep[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 3) == 0) s = AMASK - int'($urandom_range(0, 3));
          else s = int'($urandom_range(0, AMASK));
          set_frame(c, s, (s + int'($urandom_range(0, 6))) & AMASK);
        end
        sreq[c] = ($urandom_range(0, 2) == 0);
      end
      slot_en = 1'($urandom_range(0, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
